rr_channel_mux4: RTL and testbench

//  Four-channel round-robin merger: the collecting end of the 1:4 demux path.

---
 rtl/rr_channel_mux4.sv | 108 ++++++++++
 tb/tb_rr_channel_mux4.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_channel_mux4.sv
// Four-channel round-robin merger onto one registered valid/ready stream.
// Each output beat carries its source index; packet mode locks the grant until last.
module rr_channel_mux4 #(
    parameter int DATA_W   = 8,
    parameter bit PKT_MODE = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          in_valid,
    input  logic [4*DATA_W-1:0] in_data,
    input  logic [3:0]          in_last,
    output logic [3:0]          in_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_last,
    output logic [1:0]          out_sel,
    input  logic                out_ready,
    output logic                busy
);

    typedef enum logic {ARB, HOLD} state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr;
    logic [1:0] hold_ch;
    logic [1:0] grant;
    logic [1:0] sel;
    logic       any_valid;
    logic       load_en;
    logic       xfer;
    logic       sel_last;

    // The output slot can take a new beat when empty or being drained this cycle.
    assign load_en  = !out_valid || out_ready;
    assign sel      = (state == HOLD) ? hold_ch : grant;
    assign sel_last = in_last[sel];
    assign xfer     = in_valid[sel] && in_ready[sel];
    assign busy     = (state == HOLD);

    // Rotating priority search: iterate from the farthest slot back to ptr so the
    // nearest valid channel in ptr, ptr+1, .. order is the last (winning) write.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        grant     = ptr;
        any_valid = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (in_valid[ptr + 2'(k)]) begin
                grant     = ptr + 2'(k);
                any_valid = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers
            // update together from pre-edge values.
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ARB:  if (xfer && PKT_MODE && !sel_last) state_nxt = HOLD;
            HOLD: if (xfer && sel_last)              state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    // Output logic: in HOLD the locked channel is offered ready regardless of valid.
    always_comb begin
        in_ready = 4'b0000;
        if (!rst && load_en) begin
            case (state)
                ARB:  if (any_valid) in_ready[grant] = 1'b1;
                HOLD: in_ready[hold_ch] = 1'b1;
                default: in_ready = 4'b0000;
            endcase
        end
    end

    // Output slot, pointer and locked channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= 2'd0;
            ptr       <= 2'd0;
            hold_ch   <= 2'd0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[sel*DATA_W +: DATA_W];
            out_last  <= sel_last;
            out_sel   <= sel;
            if (state_nxt == ARB) ptr     <= sel + 2'd1;
            else                  hold_ch <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_channel_mux4.sv
// Bench for rr_channel_mux4: a packet-mode and a beat-mode instance share inputs;
// table vectors cover beat mode, a scoreboard checks packet-mode beat order.
module tb_rr_channel_mux4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in_valid = 4'h0;
    logic [31:0] in_data = '0;
    logic [3:0]  in_last = 4'h0;
    logic        out_ready = 1'b1;

    logic [3:0]  in_ready_p, in_ready_s;
    logic        out_valid_p, out_valid_s;
    logic [7:0]  out_data_p, out_data_s;
    logic        out_last_p, out_last_s;
    logic [1:0]  out_sel_p, out_sel_s;
    logic        busy_p, busy_s;

    rr_channel_mux4 #(.DATA_W(8), .PKT_MODE(1'b1)) u_pkt (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready_p), .out_valid(out_valid_p), .out_data(out_data_p),
        .out_last(out_last_p), .out_sel(out_sel_p), .out_ready(out_ready), .busy(busy_p));

    rr_channel_mux4 #(.DATA_W(8), .PKT_MODE(1'b0)) u_str (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready_s), .out_valid(out_valid_s), .out_data(out_data_s),
        .out_last(out_last_s), .out_sel(out_sel_s), .out_ready(out_ready), .busy(busy_s));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] sel;
        logic [7:0] data;
        logic       lst;
    } vec_t;

    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] data;
        logic       last;
    } beat_t;

    vec_t  vt[14];
    beat_t sb_q[$];
    beat_t sb_e;
    bit    sb_en = 1'b0;
    int    n_vec = 0;
    int    n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    task automatic push(input logic [1:0] s, input logic [7:0] d, input logic l);
        sb_q.push_back('{sel: s, data: d, last: l});
    endtask

    task automatic reset_pulse();
        in_valid = 4'h0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    // Scoreboard: a packet-mode beat leaves the slot on a cycle with valid & ready.
    always @(negedge clk) begin
        if (sb_en && out_valid_p && out_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL sb_unexpected: got sel %0d data %0h, expected no beat", out_sel_p, out_data_p);
            end else begin
                sb_e = sb_q.pop_front();
                check("sb_sel",  32'(out_sel_p),  32'(sb_e.sel));
                check("sb_data", 32'(out_data_p), 32'(sb_e.data));
                check("sb_last", 32'(out_last_p), 32'(sb_e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        // Beat-mode vectors: ch0=A5 ch1=11 ch2=12 ch3=13, last on ch0 and ch2.
        //            valid last  rdy  in_rdy ov  sel   data   lst
        vt[0]  = '{4'hF, 4'h5, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA5, 1'b1};
        vt[1]  = '{4'hF, 4'h5, 1'b1, 4'h2, 1'b1, 2'd1, 8'h11, 1'b0};
        vt[2]  = '{4'hF, 4'h5, 1'b1, 4'h4, 1'b1, 2'd2, 8'h12, 1'b1};
        vt[3]  = '{4'hF, 4'h5, 1'b1, 4'h8, 1'b1, 2'd3, 8'h13, 1'b0};
        vt[4]  = '{4'hF, 4'h5, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA5, 1'b1};
        vt[5]  = '{4'hF, 4'h5, 1'b0, 4'h0, 1'b1, 2'd0, 8'hA5, 1'b1};
        vt[6]  = '{4'hF, 4'h5, 1'b0, 4'h0, 1'b1, 2'd0, 8'hA5, 1'b1};
        vt[7]  = '{4'hF, 4'h5, 1'b0, 4'h0, 1'b1, 2'd0, 8'hA5, 1'b1};
        vt[8]  = '{4'hF, 4'h5, 1'b1, 4'h2, 1'b1, 2'd1, 8'h11, 1'b0};
        vt[9]  = '{4'h8, 4'h5, 1'b1, 4'h8, 1'b1, 2'd3, 8'h13, 1'b0};
        vt[10] = '{4'h0, 4'h5, 1'b1, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0};
        vt[11] = '{4'h4, 4'h5, 1'b0, 4'h4, 1'b1, 2'd2, 8'h12, 1'b1};
        vt[12] = '{4'h0, 4'h5, 1'b0, 4'h0, 1'b1, 2'd2, 8'h12, 1'b1};
        vt[13] = '{4'h0, 4'h5, 1'b1, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0};

        // Reset with every channel requesting, then release.
        set_data(8'hA5, 8'h11, 8'h12, 8'h13);
        in_valid = 4'hF;
        in_last  = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready_p",  32'(in_ready_p),  32'h0);
        check("rst in_ready_s",  32'(in_ready_s),  32'h0);
        check("rst out_valid_p", 32'(out_valid_p), 32'h0);
        check("rst out_sel_p",   32'(out_sel_p),   32'h0);
        check("rst busy_p",      32'(busy_p),      32'h0);
        rst = 1'b0;
        #1;
        check("rel in_ready_p", 32'(in_ready_p), 32'h1);
        step();
        check("rel out_valid_p", 32'(out_valid_p), 32'h1);
        check("rel out_sel_p",   32'(out_sel_p),   32'h0);
        check("rel out_data_p",  32'(out_data_p),  32'hA5);
        in_valid = 4'h0;
        #1;
        check("idle in_ready_p", 32'(in_ready_p), 32'h0);
        step();
        check("drain out_valid_p", 32'(out_valid_p), 32'h0);

        // Beat-mode table: rotation, stall, sparse requests, drain.
        reset_pulse();
        for (int i = 0; i < 14; i++) begin
            in_valid  = vt[i].valid;
            in_last   = vt[i].last;
            out_ready = vt[i].ordy;
            #1;
            check($sformatf("v%0d in_ready", i), 32'(in_ready_s), 32'(vt[i].rdy));
            step();
            check($sformatf("v%0d out_valid", i), 32'(out_valid_s), 32'(vt[i].ov));
            if (vt[i].ov) begin
                check($sformatf("v%0d out_sel", i),  32'(out_sel_s),  32'(vt[i].sel));
                check($sformatf("v%0d out_data", i), 32'(out_data_s), 32'(vt[i].data));
                check($sformatf("v%0d out_last", i), 32'(out_last_s), 32'(vt[i].lst));
            end
            check($sformatf("v%0d busy", i), 32'(busy_s), 32'h0);
        end

        // Packet on ch2 holds the grant while ch0/ch1 wait, including an idle cycle.
        out_ready = 1'b1;
        reset_pulse();
        sb_en = 1'b1;
        set_data(8'h30, 8'h31, 8'h21, 8'h00);
        in_last  = 4'b0011;
        in_valid = 4'b0100;
        push(2'd2, 8'h21, 1'b0);
        #1; check("pkt a in_ready", 32'(in_ready_p), 32'h4);
        step(); check("pkt a busy", 32'(busy_p), 32'h1);
        set_data(8'h30, 8'h31, 8'h22, 8'h00);
        in_valid = 4'b0111;
        push(2'd2, 8'h22, 1'b0);
        #1; check("pkt b in_ready", 32'(in_ready_p), 32'h4);
        step(); check("pkt b busy", 32'(busy_p), 32'h1);
        in_valid = 4'b0011;
        #1; check("pkt idle in_ready", 32'(in_ready_p), 32'h4);
        step(); check("pkt idle busy", 32'(busy_p), 32'h1);
        set_data(8'h30, 8'h31, 8'h23, 8'h00);
        in_last  = 4'b0111;
        in_valid = 4'b0111;
        push(2'd2, 8'h23, 1'b1);
        #1; check("pkt c in_ready", 32'(in_ready_p), 32'h4);
        step(); check("pkt c busy", 32'(busy_p), 32'h0);
        in_valid = 4'b0011;
        push(2'd0, 8'h30, 1'b1);
        #1; check("pkt d in_ready", 32'(in_ready_p), 32'h1);
        step();
        in_valid = 4'b0010;
        push(2'd1, 8'h31, 1'b1);
        #1; check("pkt e in_ready", 32'(in_ready_p), 32'h2);
        step();
        in_valid = 4'h0;
        step();

        // Sole valid channel streams back-to-back.
        in_last = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            set_data(8'h00, 8'(8'h40 + k), 8'h00, 8'h00);
            in_valid = 4'b0010;
            push(2'd1, 8'(8'h40 + k), 1'b1);
            #1; check($sformatf("solo%0d in_ready", k), 32'(in_ready_p), 32'h2);
            step();
            check($sformatf("solo%0d out_valid", k), 32'(out_valid_p), 32'h1);
        end
        in_valid = 4'h0;
        step();
        check("solo drained", 32'(out_valid_p), 32'h0);

        // Backpressure: A5 held for 3 cycles, then the pending 5A follows.
        set_data(8'hA5, 8'h00, 8'h00, 8'h00);
        in_last  = 4'b0001;
        in_valid = 4'b0001;
        push(2'd0, 8'hA5, 1'b1);
        #1; check("bp load in_ready", 32'(in_ready_p), 32'h1);
        step();
        out_ready = 1'b0;
        set_data(8'h5A, 8'h00, 8'h00, 8'h00);
        for (int k = 0; k < 3; k++) begin
            #1; check($sformatf("bp%0d in_ready", k), 32'(in_ready_p), 32'h0);
            step();
            check($sformatf("bp%0d out_data", k),  32'(out_data_p),  32'hA5);
            check($sformatf("bp%0d out_valid", k), 32'(out_valid_p), 32'h1);
        end
        out_ready = 1'b1;
        push(2'd0, 8'h5A, 1'b1);
        #1; check("bp release in_ready", 32'(in_ready_p), 32'h1);
        step(); check("bp next out_data", 32'(out_data_p), 32'h5A);
        in_valid = 4'h0;
        step();
        step();
        check("sb empty", 32'(sb_q.size()), 32'h0);
        sb_en = 1'b0;

        // Reset in the middle of a ch3 packet.
        set_data(8'h70, 8'h00, 8'h00, 8'h61);
        in_last  = 4'h0;
        in_valid = 4'b1000;
        #1; check("hold3 in_ready", 32'(in_ready_p), 32'h8);
        step();
        check("hold3 busy",    32'(busy_p),    32'h1);
        check("hold3 out_sel", 32'(out_sel_p), 32'h3);
        rst = 1'b1;
        #1;
        check("midrst busy",      32'(busy_p),      32'h0);
        check("midrst out_valid", 32'(out_valid_p), 32'h0);
        check("midrst out_sel",   32'(out_sel_p),   32'h0);
        in_valid = 4'b1001;
        #1; check("midrst in_ready", 32'(in_ready_p), 32'h0);
        rst = 1'b0;
        #1; check("post rst in_ready", 32'(in_ready_p), 32'h1);
        step();
        check("post rst out_sel",   32'(out_sel_p),   32'h0);
        check("post rst out_data",  32'(out_data_p),  32'h70);
        check("post rst out_valid", 32'(out_valid_p), 32'h1);
        check("post rst busy",      32'(busy_p),      32'h1);
        in_valid = 4'h0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
